// File: rtl/adma_cm_desc_sched.sv
// Per-channel descriptor scheduler: walks the eligible descriptors in rotating order,
// issues one start at a time, waits for completion and pulses the per-descriptor done-set.
module adma_cm_desc_sched #(
    parameter int unsigned DMA_DESC_DEPTH = 4,
    parameter int unsigned DESC_IDX_W     = (DMA_DESC_DEPTH > 1) ? $clog2(DMA_DESC_DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      chn_en,
    input  logic                      chn_xfer_cyclic,
    input  logic [DMA_DESC_DEPTH-1:0] desc_vld,
    input  logic [DMA_DESC_DEPTH-1:0] xfer_done,
    output logic                      xfer_start_vld,
    input  logic                      xfer_start_rdy,
    output logic [DESC_IDX_W-1:0]     xfer_desc_idx,
    input  logic                      xfer_cpl,
    output logic [DMA_DESC_DEPTH-1:0] xfer_done_set,
    output logic                      chn_busy,
    output logic                      chn_done
);

    localparam int unsigned           DEPTH    = DMA_DESC_DEPTH;
    localparam logic [DESC_IDX_W-1:0] LAST_IDX = DESC_IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_REQ,
        S_BUSY,
        S_CPL
    } state_t;

    state_t                state;
    logic [DESC_IDX_W-1:0] ptr;

    logic [DEPTH-1:0]      elig_c;
    logic [DEPTH-1:0]      elig_pred_c;
    logic [DESC_IDX_W-1:0] ptr_nxt_c;
    logic [DESC_IDX_W-1:0] sel_c;
    logic [DESC_IDX_W-1:0] sel_pred_c;
    logic                  sel_found_c;
    logic                  sel_pred_found_c;
    logic                  done_pred_c;

    // First set bit of mask at or after start, wrapping; returns {found, index}.
    function automatic logic [DESC_IDX_W:0] pick(input logic [DEPTH-1:0] mask,
                                                 input logic [DESC_IDX_W-1:0] start);
        logic                  found;
        logic [DESC_IDX_W-1:0] idx;
        int unsigned           pos;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            pos = 32'(start) + k;
            if (pos >= DEPTH) begin
                pos = pos - DEPTH;
            end
            if (!found && mask[DESC_IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = DESC_IDX_W'(pos);
            end
        end
        return {found, idx};
    endfunction

    // In CPL the status block has not yet absorbed xfer_done_set, so the pass-complete
    // decision for the following ARB cycle is made against the predicted status.
    always_comb begin
        elig_c      = desc_vld & (chn_xfer_cyclic ? {DEPTH{1'b1}} : ~xfer_done);
        elig_pred_c = desc_vld & (chn_xfer_cyclic ? {DEPTH{1'b1}} : ~(xfer_done | xfer_done_set));
        ptr_nxt_c   = (xfer_desc_idx == LAST_IDX) ? '0 : xfer_desc_idx + 1'b1;
        {sel_found_c, sel_c}           = pick(elig_c, ptr);
        {sel_pred_found_c, sel_pred_c} = pick(elig_pred_c, ptr_nxt_c);
        done_pred_c = chn_xfer_cyclic ? (sel_pred_found_c && (sel_pred_c <= xfer_desc_idx))
                                      : !sel_pred_found_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            xfer_start_vld <= 1'b0;
            xfer_desc_idx  <= '0;
            xfer_done_set  <= '0;
            chn_busy       <= 1'b0;
            chn_done       <= 1'b0;
        end else begin
            xfer_done_set <= '0;
            chn_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (chn_en) begin
                        state    <= S_ARB;
                        chn_busy <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (!sel_found_c) begin
                        state    <= S_IDLE;
                        chn_busy <= 1'b0;
                    end else begin
                        xfer_desc_idx  <= sel_c;
                        xfer_start_vld <= 1'b1;
                        state          <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A raised request is held until accepted, regardless of chn_en.
                    if (xfer_start_rdy) begin
                        xfer_start_vld <= 1'b0;
                        state          <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (xfer_cpl) begin
                        xfer_done_set <= DEPTH'(1) << xfer_desc_idx;
                        state         <= S_CPL;
                    end
                end
                S_CPL: begin
                    ptr <= ptr_nxt_c;
                    if (chn_en) begin
                        state    <= S_ARB;
                        chn_done <= done_pred_c;
                    end else begin
                        state    <= S_IDLE;
                        chn_busy <= 1'b0;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    xfer_start_vld <= 1'b0;
                    chn_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adma_cm_desc_sched.sv
// Scoreboard bench for adma_cm_desc_sched: a rotation model predicts each start index,
// done-set and pass-complete pulse; a monitor checks them as the DUT presents them.
module tb_adma_cm_desc_sched;

    localparam int unsigned D = 4;
    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         chn_en;
    logic         chn_xfer_cyclic;
    logic [D-1:0] desc_vld;
    logic [D-1:0] xfer_done;
    logic         xfer_start_vld;
    logic         xfer_start_rdy;
    logic [W-1:0] xfer_desc_idx;
    logic         xfer_cpl;
    logic [D-1:0] xfer_done_set;
    logic         chn_busy;
    logic         chn_done;

    adma_cm_desc_sched #(.DMA_DESC_DEPTH(D), .DESC_IDX_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .chn_en         (chn_en),
        .chn_xfer_cyclic(chn_xfer_cyclic),
        .desc_vld       (desc_vld),
        .xfer_done      (xfer_done),
        .xfer_start_vld (xfer_start_vld),
        .xfer_start_rdy (xfer_start_rdy),
        .xfer_desc_idx  (xfer_desc_idx),
        .xfer_cpl       (xfer_cpl),
        .xfer_done_set  (xfer_done_set),
        .chn_busy       (chn_busy),
        .chn_done       (chn_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit flag;
    } exp_t;

    int     n_err = 0;
    int     n_chk = 0;
    exp_t   exp_q[$];
    int     model_ptr = 0;
    int     hs_cnt = 0;
    int     cpl_cnt = 0;

    bit           rdy_hold = 1'b0;
    bit           rdy_rand = 1'b0;
    int           lat_min = 5;
    int           lat_max = 5;
    int           load_seq = 0;
    int           load_ack = 0;
    logic [D-1:0] load_val = '0;
    int           spur_req = 0;
    int           spur_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Datapath and status-block model: accepts starts, returns cpl, accumulates done status.
    initial begin
        int           cd;
        bit           hs;
        logic [D-1:0] ds;
        cd             = 0;
        xfer_done      = '0;
        xfer_cpl       = 1'b0;
        xfer_start_rdy = 1'b0;
        forever begin
            @(negedge clk);
            hs = xfer_start_vld && xfer_start_rdy && !rst;
            ds = rst ? '0 : xfer_done_set;
            @(posedge clk);
            #1;
            if (rst) cd = 0;
            xfer_done = xfer_done | ds;
            if (load_seq != load_ack) begin
                xfer_done = load_val;
                load_ack  = load_seq;
            end
            xfer_cpl = 1'b0;
            if (hs) cd = $urandom_range(lat_max, lat_min);
            if (cd > 0) begin
                cd--;
                if (cd == 0) xfer_cpl = 1'b1;
            end else if (spur_req != spur_done) begin
                xfer_cpl  = 1'b1;
                spur_done = spur_req;
            end
            xfer_start_rdy = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: compares every start, done-set and chn_done against the scoreboard.
    initial begin
        exp_t         e;
        exp_t         pend_q[$];
        bit           dpend;
        bit           dexp;
        bit           pwait;
        logic [W-1:0] pidx;
        dpend = 1'b0;
        dexp  = 1'b0;
        pwait = 1'b0;
        pidx  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dpend = 1'b0;
                pwait = 1'b0;
                pend_q.delete();
            end else begin
                if (dpend) begin
                    check("chn_done", 32'(chn_done), 32'(dexp));
                    dpend = 1'b0;
                end else if (chn_done) begin
                    check("chn_done_unexpected", 32'(chn_done), 32'd0);
                end
                if (pwait) begin
                    check("req_vld_held", 32'(xfer_start_vld), 32'd1);
                    check("req_idx_held", 32'(xfer_desc_idx), 32'(pidx));
                end
                if (xfer_done_set != '0) begin
                    cpl_cnt++;
                    if (pend_q.size() == 0) begin
                        check("done_set_unexpected", 32'(xfer_done_set), 32'd0);
                    end else begin
                        e = pend_q.pop_front();
                        check("done_set", 32'(xfer_done_set), 32'(1) << e.idx);
                        dpend = 1'b1;
                        dexp  = e.flag;
                    end
                end
                if (xfer_start_vld && xfer_start_rdy) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        check("start_unexpected", 32'(xfer_start_vld), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("start_idx", 32'(xfer_desc_idx), 32'(e.idx));
                        pend_q.push_back(e);
                    end
                end
                pwait = xfer_start_vld && !xfer_start_rdy;
                pidx  = xfer_desc_idx;
            end
        end
    end

    // Reference: eligible descriptors in rotating order from the pointer. One-shot visits
    // each once and flags the last; cyclic repeats and flags a completion whose successor wraps.
    task automatic model_push(input logic [D-1:0] vld, input logic [D-1:0] done, input bit cyc,
                              input int n, input bit abort, output int cnt);
        int   l[$];
        int   i;
        exp_t e;
        for (int k = 0; k < D; k++) begin
            i = (model_ptr + k) % D;
            if (vld[W'(i)] && (cyc || !done[W'(i)])) l.push_back(i);
        end
        cnt = 0;
        if (l.size() == 0) return;
        cnt = (cyc || abort) ? n : l.size();
        for (int t = 0; t < cnt; t++) begin
            e.idx = l[t % l.size()];
            if (cyc) e.flag = (t < cnt - 1) && (l[(t + 1) % l.size()] <= e.idx);
            else     e.flag = !abort && (t == cnt - 1);
            exp_q.push_back(e);
            model_ptr = (e.idx + 1) % D;
        end
    endtask

    task automatic load_done(input logic [D-1:0] v);
        load_val = v;
        load_seq++;
        tick(2);
    endtask

    task automatic go_idle();
        chn_en = 1'b0;
        for (int t = 0; t < 20 && chn_busy; t++) tick(1);
        check("idle_busy", 32'(chn_busy), 32'd0);
    endtask

    task automatic wait_vld();
        for (int t = 0; t < 20 && !xfer_start_vld; t++) tick(1);
        check("wait_vld", 32'(xfer_start_vld), 32'd1);
    endtask

    task automatic wait_cpl(input int target);
        for (int t = 0; t < 600 && cpl_cnt < target; t++) tick(1);
        check("cpl_count", 32'(cpl_cnt), 32'(target));
    endtask

    task automatic run_pass(input logic [D-1:0] vld, input logic [D-1:0] done, input bit cyc,
                            input int n);
        int cnt;
        int hs_base;
        int cpl_base;
        go_idle();
        chn_xfer_cyclic = cyc;
        desc_vld        = vld;
        load_done(done);
        model_push(vld, done, cyc, n, cyc, cnt);
        hs_base  = hs_cnt;
        cpl_base = cpl_cnt;
        chn_en   = 1'b1;
        if (cyc) begin
            for (int t = 0; t < 600 && hs_cnt < hs_base + cnt; t++) tick(1);
            chn_en = 1'b0;
        end
        wait_cpl(cpl_base + cnt);
        tick(3);
        go_idle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        int cpl_base;
        rst             = 1'b1;
        chn_en          = 1'b0;
        chn_xfer_cyclic = 1'b0;
        desc_vld        = '0;

        @(negedge clk);
        check("rst_vld", 32'(xfer_start_vld), 32'd0);
        check("rst_idx", 32'(xfer_desc_idx), 32'd0);
        check("rst_done_set", 32'(xfer_done_set), 32'd0);
        check("rst_busy", 32'(chn_busy), 32'd0);
        check("rst_chn_done", 32'(chn_done), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Reset asserted while a request is pending.
        desc_vld = 4'b1111;
        load_done('0);
        rdy_hold = 1'b1;
        chn_en   = 1'b1;
        wait_vld();
        tick(2);
        rst = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        check("midrst_vld", 32'(xfer_start_vld), 32'd0);
        check("midrst_busy", 32'(chn_busy), 32'd0);
        check("midrst_idx", 32'(xfer_desc_idx), 32'd0);
        chn_en = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(30);
        check("idle_stays_busy", 32'(chn_busy), 32'd0);
        check("idle_stays_vld", 32'(xfer_start_vld), 32'd0);
        rdy_hold = 1'b0;

        run_pass(4'b1011, 4'b0000, 1'b0, 0);
        run_pass(4'b1111, 4'b0101, 1'b0, 0);
        run_pass(4'b0110, 4'b0000, 1'b1, 5);
        run_pass(4'b0001, 4'b0000, 1'b1, 3);

        // Backpressure with chn_en dropped during REQ: one transfer completes, then idle.
        go_idle();
        chn_xfer_cyclic = 1'b0;
        desc_vld        = 4'b1111;
        load_done('0);
        model_push(4'b1111, 4'b0000, 1'b0, 1, 1'b1, cnt);
        cpl_base = cpl_cnt;
        rdy_hold = 1'b1;
        chn_en   = 1'b1;
        wait_vld();
        tick(3);
        chn_en = 1'b0;
        tick(7);
        check("bp_vld_still", 32'(xfer_start_vld), 32'd1);
        rdy_hold = 1'b0;
        wait_cpl(cpl_base + 1);
        tick(20);
        check("bp_idle_busy", 32'(chn_busy), 32'd0);
        check("bp_no_req", 32'(xfer_start_vld), 32'd0);
        check("bp_exp_q", 32'(exp_q.size()), 32'd0);

        // Spurious completions in IDLE and in REQ.
        go_idle();
        spur_req++;
        tick(4);
        check("spur_idle_busy", 32'(chn_busy), 32'd0);
        desc_vld = 4'b0001;
        load_done('0);
        model_push(4'b0001, 4'b0000, 1'b0, 0, 1'b0, cnt);
        cpl_base = cpl_cnt;
        rdy_hold = 1'b1;
        chn_en   = 1'b1;
        wait_vld();
        spur_req++;
        tick(4);
        check("spur_req_vld", 32'(xfer_start_vld), 32'd1);
        rdy_hold = 1'b0;
        wait_cpl(cpl_base + cnt);
        tick(3);
        go_idle();
        check("spur_exp_q", 32'(exp_q.size()), 32'd0);

        // Randomized passes with random readiness and completion latency.
        rdy_rand = 1'b1;
        lat_min  = 1;
        lat_max  = 6;
        for (int r = 0; r < 12; r++) begin
            if (r % 3 == 2) run_pass(D'($urandom), D'($urandom), 1'b1, $urandom_range(1, 6));
            else            run_pass(D'($urandom), D'($urandom), 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
